// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, strobe and latency-counter sizing.
package data_mem_responder_pkg;

  localparam int unsigned StrbWidth  = 4;
  localparam int unsigned LatencyMax = 15;
  localparam int unsigned CntWidth   = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } memState_e;

endpackage

// File: rtl/data_mem_responder_byte_strobe_ram.sv
// Word-organised RAM with per-byte-lane synchronous write enables and a combinational read port.
module byte_strobe_ram
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned WordBits = 8
) (
  input  logic                 clk,
  input  logic [StrbWidth-1:0] we,
  input  logic [WordBits-1:0]  addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  localparam int unsigned Depth = 1 << WordBits;

  logic [31:0] mem [Depth];

  always_ff @(posedge clk) begin
    for (int i = 0; i < StrbWidth; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: single outstanding request, programmable latency, byte-strobed writes,
// read response held until acknowledged.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ack,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ack
);

  localparam int unsigned WordBits = ADDR_WIDTH - 2;

  memState_e             state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [WordBits-1:0]   wordAddr_q;
  logic [31:0]           wdata_q;
  logic [StrbWidth-1:0]  strb_q;
  logic                  isWrite_q;
  logic [31:0]           readData_q;
  logic                  accept;
  logic                  done;
  logic [StrbWidth-1:0]  ramWe;
  logic [31:0]           ramRdata;
  logic                  unusedAddr;

  assign unusedAddr = ^{Address[31:ADDR_WIDTH], Address[1:0]};

  assign accept = (state_q == StIdle) && (MemRead || MemWrite);
  assign done   = (state_q == StWait) && (cnt_q == '0);
  // Write commits only at completion so a reset during the wait abandons it.
  assign ramWe  = (done && isWrite_q) ? strb_q : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          cnt_d   = CntWidth'(LATENCY - 1);
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntWidth'(1);
        end else begin
          state_d = isWrite_q ? StIdle : StResp;
        end
      end
      StResp: begin
        if (Read_data_Ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wordAddr_q <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      isWrite_q  <= 1'b0;
      readData_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wordAddr_q <= Address[ADDR_WIDTH-1:2];
        wdata_q    <= Write_data;
        strb_q     <= Write_strb;
        isWrite_q  <= MemWrite;
      end
      if (done && !isWrite_q) begin
        readData_q <= ramRdata;
      end
    end
  end

  byte_strobe_ram #(
    .WordBits(WordBits)
  ) u_ram (
    .clk  (clk),
    .we   (ramWe),
    .addr (wordAddr_q),
    .wdata(wdata_q),
    .rdata(ramRdata)
  );

  assign Mem_Req_Ack     = (state_q == StIdle) && rst;
  assign Read_data_Valid = (state_q == StResp);
  assign Read_data       = readData_q;

endmodule
